keypad_entry: RTL and testbench
===============================

# keypad_entry

Upstream input stage for `door_security`: turns raw keypad strobes into the 12-bit `passin` word and the `enter` strobe that `door_security` samples. Debounces each key, collects three hex digits most-significant first, and validates the ENTER command. Clears partial entries on CLEAR, on inactivity timeout, or while the downstream alarm holds the keypad locked out.

## Interface
- `DIGITS`, 3: hex digits per password. `passin` width is 4*DIGITS = 12.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples needed to accept a press or a release (≥2).
- `TIMEOUT_CYCLES`, 1000: idle cycles after the last accepted key before a partial entry is discarded.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `key_valid`  in  1  raw level from keypad scanner, high while a key is down.
- `key_code`  in  5  0x00–0x0F hex digit; 0x10 ENTER; 0x11 CLEAR; other codes are ignored.
- `lockout`  in  1  from `door_security` `alram`; inhibits entry while high.
- `passin`  out  12  assembled password, to `door_security.passin`.
- `enter`  out  1  one-cycle strobe, to `door_security.enter`.
- `digit_count`  out  2  digits currently buffered (0..DIGITS).
- `entry_error`  out  1  one-cycle pulse: ENTER on a short entry, or a digit while full.
- `timed_out`  out  1  one-cycle pulse: partial entry discarded by timeout.

## Operation
- Reset values: `passin`=0, `enter`=0, `digit_count`=0, `entry_error`=0, `timed_out`=0. Debouncer in IDLE, timeout counter 0.
- Debouncer states: IDLE → PRESS_CHK when `key_valid`=1.
  - PRESS_CHK → IDLE on any low sample.
  - On the DEBOUNCE_CYCLES-th consecutive high sample: accept the event, latch `key_code` from that sample, go to HELD.
  - HELD → REL_CHK when `key_valid`=0.
  - REL_CHK → HELD on any high sample; → IDLE after DEBOUNCE_CYCLES consecutive low samples.
  - Exactly one event per physical press. A key held indefinitely produces one event.
- Entry FSM on an accepted event:
  - Digit with `digit_count` < DIGITS: `passin` ← {passin[7:0], digit}; if `digit_count`=0, `passin` ← {8'h000, digit}. `digit_count`+1.
  - Digit with `digit_count` = DIGITS: ignored, `entry_error` pulses, `passin` unchanged.
  - ENTER with `digit_count` = DIGITS: `enter` pulses. `passin` is held until the next accepted digit. `digit_count` ← 0.
  - ENTER with `digit_count` < DIGITS: `entry_error` pulses; `passin` ← 0, `digit_count` ← 0. No `enter`.
  - CLEAR: `passin` ← 0, `digit_count` ← 0. No pulse.
- Timeout counter:
  - Runs only while `digit_count` > 0. Restarts at 0 on every accepted event.
  - On reaching TIMEOUT_CYCLES: `timed_out` pulses, `passin` ← 0, `digit_count` ← 0.
- Lockout:
  - While `lockout`=1, accepted events are discarded. `passin` and `digit_count` are forced to 0, the timeout counter is held at 0, and no pulses are generated.
  - The debouncer keeps tracking, so a key held across lockout deassertion is not re-accepted.

## Timing
- Latency: if the first high sample of `key_valid` is at edge k, the event is accepted at edge k+DEBOUNCE_CYCLES−1. `passin`, `digit_count`, `enter`, `entry_error` update at edge k+DEBOUNCE_CYCLES. All outputs are registered.
- `enter` is high for exactly one cycle. `passin` is stable in that cycle and the cycle before it, so `door_security` samples a settled word.
- Simultaneous events:
  - `lockout` with an accepted event: lockout wins.
  - Timeout expiry with an accepted event: the event wins and the counter restarts.
  - `reset` mid-debounce or mid-entry: immediate clear. A key held through reset deassertion is accepted as a new press after DEBOUNCE_CYCLES samples.

## Structure
- Package `keypad_pkg`: KEY_ENTER=5'h10, KEY_CLEAR=5'h11, debouncer state enum {IDLE, PRESS_CHK, HELD, REL_CHK}, function `is_digit(code)`.
- Sub-module `key_debounce`: parameter DEBOUNCE_CYCLES; ports `clk`, `reset`, `key_valid`, `key_code` in; `key_event` (1-cycle) and `event_code` out.
- Entry FSM, timeout counter and output registers live in `keypad_entry`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, with each key held 6 cycles and released 6 cycles.
- Keys A, 0, 8, ENTER → `passin`=12'hA08, `enter` high one cycle, `digit_count` 0 afterwards. Then `door_security` with `set_password`=12'hA08 grants access.
- `key_valid` high for 3 cycles (glitch), then low → no event, all outputs unchanged.
- Keys F, E, ENTER → `entry_error` one pulse, no `enter`, `passin`=0, `digit_count`=0.
- Keys 1, 2, 3, 4 → `passin`=12'h123, `entry_error` pulse on the 4th key, `digit_count`=3.
- Key 5, then idle 64 cycles → `timed_out` one pulse, `passin`=0, `digit_count`=0.
- Keys 7, 7, then `lockout`=1 → `digit_count`=0 immediately, and a press during lockout is ignored. Separately, `reset` asserted during PRESS_CHK → all outputs 0 at once.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, debouncer state type and code classification for the keypad entry path.
package keypad_pkg;

  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_CLEAR = 5'h11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } db_state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code[4] == 1'b0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the raw key level into one registered event per physical press,
// capturing the key code from the sample that completes the press check.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_event,
  output logic [4:0] event_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  db_state_t     state;
  logic [CW-1:0] cnt;

  // cnt holds the number of consecutive qualifying samples already seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key_event  <= 1'b0;
      event_code <= '0;
    end else begin
      key_event <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            state <= PRESS_CHK;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!key_valid) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state      <= HELD;
            key_event  <= 1'b1;
            event_code <= key_code;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_valid) begin
            state <= REL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        REL_CHK: begin
          if (key_valid) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Collects debounced hex digits into the password word, validates ENTER and
// discards partial entries on CLEAR, inactivity timeout or downstream lockout.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  input  logic                lockout,
  output logic [4*DIGITS-1:0] passin,
  output logic                enter,
  output logic [1:0]          digit_count,
  output logic                entry_error,
  output logic                timed_out
);

  localparam int PW = 4 * DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]    FULL   = 2'(DIGITS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          key_event;
  logic [4:0]    event_code;
  logic [TW-1:0] idle_cnt;
  logic          is_dig;
  logic          is_ent;
  logic          is_clr;
  logic          accept;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_event (key_event),
    .event_code(event_code)
  );

  assign is_dig = is_digit(event_code);
  assign is_ent = (event_code == KEY_ENTER);
  assign is_clr = (event_code == KEY_CLEAR);
  // Unknown codes are dropped here so they neither edit the entry nor refresh the timer.
  assign accept = key_event && (is_dig || is_ent || is_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      passin      <= '0;
      enter       <= 1'b0;
      digit_count <= '0;
      entry_error <= 1'b0;
      timed_out   <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      enter       <= 1'b0;
      entry_error <= 1'b0;
      timed_out   <= 1'b0;
      if (lockout) begin
        passin      <= '0;
        digit_count <= '0;
        idle_cnt    <= '0;
      end else if (accept) begin
        idle_cnt <= '0;
        if (is_dig) begin
          if (digit_count == FULL) begin
            entry_error <= 1'b1;
          end else begin
            passin      <= (digit_count == 2'd0) ? PW'(event_code[3:0])
                                                 : {passin[PW-5:0], event_code[3:0]};
            digit_count <= digit_count + 1'b1;
          end
        end else if (is_ent) begin
          // A complete word stays on passin after ENTER until the next digit arrives.
          if (digit_count == FULL) begin
            enter <= 1'b1;
          end else begin
            entry_error <= 1'b1;
            passin      <= '0;
          end
          digit_count <= '0;
        end else begin
          passin      <= '0;
          digit_count <= '0;
        end
      end else if (digit_count != 2'd0) begin
        if (idle_cnt == T_LAST) begin
          timed_out   <= 1'b1;
          passin      <= '0;
          digit_count <= '0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed and randomized key sequences checked against a press-level model of the entry rules.
module tb_keypad_entry;
  import keypad_pkg::*;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        lockout;
  logic [11:0] passin;
  logic        enter;
  logic [1:0]  digit_count;
  logic        entry_error;
  logic        timed_out;

  int checks   = 0;
  int failures = 0;
  int n_enter  = 0;
  int n_err    = 0;
  int n_to     = 0;
  int e0, r0, t0;
  logic [11:0] enter_word  = '0;
  logic [11:0] prev_passin = '0;

  keypad_entry #(
    .DIGITS         (3),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .lockout    (lockout),
    .passin     (passin),
    .enter      (enter),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .timed_out  (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor; passin must already be settled in the cycle before enter.
  always @(negedge clk) begin
    if (enter) begin
      n_enter++;
      enter_word = passin;
      check("enter_stable", 32'(passin), 32'(prev_passin));
    end
    if (entry_error) n_err++;
    if (timed_out) n_to++;
    prev_passin = passin;
  end

  task automatic snap();
    e0 = n_enter;
    r0 = n_err;
    t0 = n_to;
  endtask

  task automatic step_check(input string tag, input logic [11:0] exp_p, input logic [1:0] exp_c,
                            input int d_e, input int d_r, input int d_t);
    check({tag, ".passin"}, 32'(passin), 32'(exp_p));
    check({tag, ".count"}, 32'(digit_count), 32'(exp_c));
    check({tag, ".enter_n"}, 32'(n_enter - e0), 32'(d_e));
    check({tag, ".error_n"}, 32'(n_err - r0), 32'(d_r));
    check({tag, ".timeout_n"}, 32'(n_to - t0), 32'(d_t));
  endtask

  task automatic press(input logic [4:0] code, input int hold, input int rel);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'($urandom_range(0, 31));
    repeat (rel) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] m_passin;
    logic [1:0]  m_count;
    logic [4:0]  code;
    int r, d_e, d_r, d_t;
    bit long_gap;

    reset = 1'b1; key_valid = 1'b0; key_code = '0; lockout = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    snap();
    step_check("reset", 12'h000, 2'd0, 0, 0, 0);

    // First high sample at edge k; outputs must move at edge k+4, not before.
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'h0A;
    repeat (4) @(negedge clk);
    check("lat_before", 32'(digit_count), 32'd0);
    @(negedge clk);
    check("lat_at.count", 32'(digit_count), 32'd1);
    check("lat_at.passin", 32'(passin), 32'h00A);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    press(5'h00, 6, 6);
    press(5'h08, 6, 6);
    check("a08.passin", 32'(passin), 32'hA08);
    check("a08.count", 32'(digit_count), 32'd3);
    snap();
    press(KEY_ENTER, 6, 6);
    step_check("enter_a08", 12'hA08, 2'd0, 1, 0, 0);
    check("grant_word", 32'(enter_word), 32'hA08);

    snap();
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'h03;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (8) @(negedge clk);
    step_check("glitch", 12'hA08, 2'd0, 0, 0, 0);

    snap();
    press(5'h0F, 6, 6);
    press(5'h0E, 6, 6);
    press(KEY_ENTER, 6, 6);
    step_check("short_enter", 12'h000, 2'd0, 0, 1, 0);

    snap();
    press(5'h01, 6, 6);
    press(5'h02, 6, 6);
    press(5'h03, 6, 6);
    press(5'h04, 6, 6);
    step_check("overflow", 12'h123, 2'd3, 0, 1, 0);
    snap();
    press(KEY_CLEAR, 6, 6);
    step_check("clear", 12'h000, 2'd0, 0, 0, 0);

    snap();
    press(5'h05, 6, 6);
    repeat (70) @(negedge clk);
    step_check("timeout", 12'h000, 2'd0, 0, 0, 1);

    press(5'h07, 6, 6);
    press(5'h07, 6, 6);
    check("pre_lock.count", 32'(digit_count), 32'd2);
    check("pre_lock.passin", 32'(passin), 32'h077);
    lockout = 1'b1;
    @(negedge clk);
    check("lock_now.count", 32'(digit_count), 32'd0);
    check("lock_now.passin", 32'(passin), 32'h000);
    snap();
    press(5'h03, 6, 6);
    step_check("lock_press", 12'h000, 2'd0, 0, 0, 0);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'h04;
    repeat (6) @(negedge clk);
    lockout = 1'b0;
    repeat (4) @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    step_check("lock_release_held", 12'h000, 2'd0, 0, 0, 0);

    press(5'h09, 6, 6);
    check("pre_rst.count", 32'(digit_count), 32'd1);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'h06;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid.passin", 32'(passin), 32'h000);
    check("rst_mid.count", 32'(digit_count), 32'd0);
    check("rst_mid.pulses", 32'({enter, entry_error, timed_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_held.count", 32'(digit_count), 32'd1);
    check("rst_held.passin", 32'(passin), 32'h006);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);

    m_passin = 12'h006;
    m_count  = 2'd1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      code = 5'($urandom_range(0, 15));
      else if (r < 78) code = KEY_ENTER;
      else if (r < 86) code = KEY_CLEAR;
      else if (m_count == 2'd0) code = 5'($urandom_range(18, 31));
      else code = 5'($urandom_range(0, 15));
      long_gap = ($urandom_range(0, 5) == 0);
      d_e = 0; d_r = 0; d_t = 0;
      if (code < 5'h10) begin
        if (m_count == 2'd3) d_r = 1;
        else begin
          m_passin = (m_count == 2'd0) ? {8'h00, code[3:0]} : {m_passin[7:0], code[3:0]};
          m_count  = m_count + 2'd1;
        end
      end else if (code == KEY_ENTER) begin
        if (m_count == 2'd3) d_e = 1;
        else begin
          d_r = 1;
          m_passin = '0;
        end
        m_count = 2'd0;
      end else if (code == KEY_CLEAR) begin
        m_passin = '0;
        m_count  = 2'd0;
      end
      snap();
      press(code, int'($urandom_range(4, 8)), int'($urandom_range(4, 8)));
      if (long_gap) begin
        repeat (int'($urandom_range(75, 95))) @(negedge clk);
        if (m_count != 2'd0) begin
          d_t = 1;
          m_passin = '0;
          m_count  = 2'd0;
        end
      end else begin
        repeat (int'($urandom_range(0, 20))) @(negedge clk);
      end
      step_check($sformatf("rand%0d", i), m_passin, m_count, d_e, d_r, d_t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
